tipi_reg_arbiter: RTL and testbench

- Owns the four 8-bit mailbox registers shared between the TI and the Raspberry Pi: TD and TC (TI to Pi), RD and RC (Pi to TI).
- Sequences the Pi nibble-serial bus (r_clk / r_le / r_nib) in the system clock domain.
- Arbitrates the single register-file write port between TI memory writes and Pi nibble-bus writes.
- Sits between the TI address decode in tipi_top and the Pi connector pins.

---
 rtl/tipi_reg_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_tipi_reg_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_reg_arbiter.sv
// tipi_reg_arbiter: owns the TD/TC/RD/RC mailbox registers shared by the TI and
// the Raspberry Pi, sequences the Pi nibble-serial bus (r_clk/r_le/r_nib) in
// the clk domain, and arbitrates the single register write port (TI first).
// Optional feature macro: TIPI_RC_IRQ_EN (interrupt on a Pi write to RC).
module tipi_reg_arbiter #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       r_clk,
   input  logic       r_le,
   input  logic [0:3] r_nib_in,
   output logic [0:3] r_nib_out,
   output logic       r_nib_oe,
   input  logic       ti_wr,
   input  logic       ti_sel,
   input  logic [0:7] ti_wdata,
   input  logic       ti_rd_rc,
   input  logic       sync_clr,
   output logic [0:7] td,
   output logic [0:7] tc,
   output logic [0:7] rd,
   output logic [0:7] rc,
   output logic       pi_busy,
   output logic       pi_wr_pending,
   output logic       irq
);

   localparam int          STAGES  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [7:0]  TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CMD, XFER_HI, XFER_LO, COMMIT} state_t;
   typedef enum logic [1:0] {SEL_TD = 2'b00, SEL_TC, SEL_RD, SEL_RC} reg_sel_t;

   logic [STAGES-1:0] clk_sync;
   logic [STAGES-1:0] le_sync;
   logic              clk_prev;
   logic              pi_edge;
   logic              cmd_edge;
   logic              data_edge;
   state_t            state;
   reg_sel_t          cmd_sel;
   logic              cmd_wr;
   logic [0:7]        shadow;
   logic [0:7]        pi_data;
   logic [7:0]        idle_cnt;
   logic [0:7]        sel_value;
   logic              waiting;
   logic              timeout_hit;
   logic              pi_grant;

   // Bring the Pi strobe and command select into the clk domain.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= '0;
         le_sync  <= '0;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[STAGES-2:0], r_clk};
         le_sync  <= {le_sync[STAGES-2:0], r_le};
         clk_prev <= clk_sync[STAGES-1];
      end
   end

   // r_le travels through the same number of stages, so it is aligned with the edge.
   assign pi_edge   = clk_sync[STAGES-1] & ~clk_prev;
   assign cmd_edge  = pi_edge & le_sync[STAGES-1];
   assign data_edge = pi_edge & ~le_sync[STAGES-1];

   // Register addressed by the nibble currently on the bus (used at a command edge).
   // NOTE: the default assignment first means no path leaves sel_value
   // unassigned, so no latch is inferred.
   always_comb begin
      sel_value = td;
      case (reg_sel_t'(r_nib_in[0:1]))
         SEL_TD: sel_value = td;
         SEL_TC: sel_value = tc;
         SEL_RD: sel_value = rd;
         SEL_RC: sel_value = rc;
      endcase
   end

   // Only CMD and XFER_HI wait on the Pi; XFER_LO and COMMIT advance on their own.
   assign waiting     = (state == CMD) || (state == XFER_HI);
   assign timeout_hit = (TIMEOUT != 0) && waiting && !pi_edge && (idle_cnt == TO_LAST);

   // The Pi gets the port only when the TI is not writing, and not when the
   // transfer is being aborted or cleared in the same cycle.
   assign pi_grant = (state == COMMIT) && !ti_wr && !cmd_edge && !sync_clr;

   assign pi_busy = (state != IDLE);

   // Nibble-bus sequencer with registered pin outputs and pending flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cmd_sel       <= SEL_TD;
         cmd_wr        <= 1'b0;
         shadow        <= '0;
         pi_data       <= '0;
         idle_cnt      <= '0;
         r_nib_out     <= '0;
         r_nib_oe      <= 1'b0;
         pi_wr_pending <= 1'b0;
      end else if (sync_clr) begin
         state         <= IDLE;
         idle_cnt      <= '0;
         r_nib_out     <= '0;
         r_nib_oe      <= 1'b0;
         pi_wr_pending <= 1'b0;
      end else begin
         if (pi_edge || !waiting) idle_cnt <= '0;
         else                     idle_cnt <= idle_cnt + 8'd1;

         if (cmd_edge) begin
            // A command edge starts (or restarts) a transfer from any state.
            state         <= CMD;
            cmd_sel       <= reg_sel_t'(r_nib_in[0:1]);
            cmd_wr        <= r_nib_in[2];
            shadow        <= sel_value;
            r_nib_out     <= r_nib_in[2] ? 4'h0 : sel_value[0:3];
            r_nib_oe      <= ~r_nib_in[2];
            pi_wr_pending <= 1'b0;
         end else if (timeout_hit) begin
            state     <= IDLE;
            r_nib_out <= '0;
            r_nib_oe  <= 1'b0;
         end else begin
            case (state)
               CMD: if (data_edge) begin
                  state <= XFER_HI;
                  if (cmd_wr) pi_data[0:3] <= r_nib_in;
                  else        r_nib_out    <= shadow[4:7];
               end
               XFER_HI: if (data_edge) begin
                  if (cmd_wr) begin
                     pi_data[4:7] <= r_nib_in;
                     state        <= XFER_LO;
                  end else begin
                     state     <= IDLE;
                     r_nib_out <= '0;
                     r_nib_oe  <= 1'b0;
                  end
               end
               XFER_LO: state <= COMMIT;
               COMMIT: begin
                  // pi_wr_pending marks a write that has been refused the port.
                  if (pi_grant) begin
                     state         <= IDLE;
                     pi_wr_pending <= 1'b0;
                  end else begin
                     pi_wr_pending <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Single write port: sync_clr, then TI, then a granted Pi write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         td <= '0;
         tc <= '0;
         rd <= '0;
         rc <= '0;
      end else if (sync_clr) begin
         td <= '0;
         tc <= '0;
         rd <= '0;
         rc <= '0;
      end else if (ti_wr) begin
         if (ti_sel) tc <= ti_wdata;
         else        td <= ti_wdata;
      end else if (pi_grant) begin
         case (cmd_sel)
            SEL_TD: td <= pi_data;
            SEL_TC: tc <= pi_data;
            SEL_RD: rd <= pi_data;
            SEL_RC: rc <= pi_data;
         endcase
      end
   end

`ifdef TIPI_RC_IRQ_EN
   // RC-written interrupt: set by a committed Pi write to RC, cleared by the TI reading RC.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          irq <= 1'b0;
      else if (sync_clr)                     irq <= 1'b0;
      else if (pi_grant && cmd_sel == SEL_RC) irq <= 1'b1;
      else if (ti_rd_rc)                     irq <= 1'b0;
   end
`else
   logic unused_ti_rd_rc;
   assign unused_ti_rd_rc = ti_rd_rc;
   assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_tipi_reg_arbiter.sv
// Self-checking bench for tipi_reg_arbiter: directed vector table, hand-written
// corner sequences (collision, timeout, abort, sync_clr, reset) and a random
// transaction phase checked against a register-level mailbox model.
module tb_tipi_reg_arbiter;

   localparam int TO = 20;
`ifdef TIPI_RC_IRQ_EN
   localparam logic IRQ_EXP = 1'b1;
`else
   localparam logic IRQ_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       r_clk = 1'b0;
   logic       r_le = 1'b0;
   logic [0:3] r_nib_in = '0;
   logic [0:3] r_nib_out;
   logic       r_nib_oe;
   logic       ti_wr = 1'b0;
   logic       ti_sel = 1'b0;
   logic [0:7] ti_wdata = '0;
   logic       ti_rd_rc = 1'b0;
   logic       sync_clr = 1'b0;
   logic [0:7] td, tc, rd, rc;
   logic       pi_busy, pi_wr_pending, irq;

   int n_tests = 0;
   int n_fail  = 0;

   // Mailbox model: index 0 TD, 1 TC, 2 RD, 3 RC.
   logic [7:0] model [4];

   tipi_reg_arbiter #(.SYNC_STAGES(2), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .r_clk(r_clk), .r_le(r_le),
      .r_nib_in(r_nib_in), .r_nib_out(r_nib_out), .r_nib_oe(r_nib_oe),
      .ti_wr(ti_wr), .ti_sel(ti_sel), .ti_wdata(ti_wdata), .ti_rd_rc(ti_rd_rc),
      .sync_clr(sync_clr), .td(td), .tc(tc), .rd(rd), .rc(rc),
      .pi_busy(pi_busy), .pi_wr_pending(pi_wr_pending), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      check({name, "_td"}, td, model[0]);
      check({name, "_tc"}, tc, model[1]);
      check({name, "_rd"}, rd, model[2]);
      check({name, "_rc"}, rc, model[3]);
   endtask

   // One Pi strobe: set r_le / nibble, raise r_clk, hold, drop, settle.
   task automatic pi_edge(input logic le, input logic [3:0] nib);
      @(posedge clk); #1;
      r_le = le;
      r_nib_in = nib;
      @(posedge clk); #1;
      r_clk = 1'b1;
      repeat (4) @(posedge clk);
      #1 r_clk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pi_read(input logic [1:0] sel, input logic [7:0] exp);
      pi_edge(1'b1, {sel, 2'b00});
      check("rd_oe_hi", r_nib_oe, 1'b1);
      check("rd_nib_hi", r_nib_out, exp[7:4]);
      pi_edge(1'b0, 4'h0);
      check("rd_oe_mid", r_nib_oe, 1'b1);
      check("rd_nib_lo", r_nib_out, exp[3:0]);
      pi_edge(1'b0, 4'h0);
      check("rd_oe_end", r_nib_oe, 1'b0);
      check("rd_busy_end", pi_busy, 1'b0);
   endtask

   task automatic pi_write(input logic [1:0] sel, input logic [7:0] data);
      pi_edge(1'b1, {sel, 2'b10});
      check("wr_oe", r_nib_oe, 1'b0);
      pi_edge(1'b0, data[7:4]);
      pi_edge(1'b0, data[3:0]);
      check("wr_busy_end", pi_busy, 1'b0);
      check("wr_pending_end", pi_wr_pending, 1'b0);
   endtask

   task automatic ti_write(input logic sel, input logic [7:0] data);
      @(posedge clk); #1;
      ti_wr = 1'b1;
      ti_sel = sel;
      ti_wdata = data;
      @(posedge clk); #1;
      ti_wr = 1'b0;
   endtask

   task automatic ti_read_rc();
      @(posedge clk); #1;
      ti_rd_rc = 1'b1;
      @(posedge clk); #1;
      ti_rd_rc = 1'b0;
   endtask

   typedef enum logic [1:0] {OP_TIW, OP_PIW, OP_PIR} op_t;
   typedef struct {
      op_t        op;
      logic [1:0] sel;
      logic [7:0] data;
      logic [7:0] exp_td, exp_tc, exp_rd, exp_rc;
   } vec_t;

   vec_t       vecs [9];
   logic       seen;
   logic [1:0] rs;
   logic [7:0] rdat;
   int         rop;

   initial begin
      vecs[0] = '{OP_TIW, 2'd0, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{OP_PIR, 2'd0, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{OP_PIW, 2'd2, 8'h3C, 8'hA5, 8'h00, 8'h3C, 8'h00};
      vecs[3] = '{OP_TIW, 2'd1, 8'h5A, 8'hA5, 8'h5A, 8'h3C, 8'h00};
      vecs[4] = '{OP_PIW, 2'd3, 8'h81, 8'hA5, 8'h5A, 8'h3C, 8'h81};
      vecs[5] = '{OP_PIR, 2'd2, 8'h3C, 8'hA5, 8'h5A, 8'h3C, 8'h81};
      vecs[6] = '{OP_PIW, 2'd0, 8'hFF, 8'hFF, 8'h5A, 8'h3C, 8'h81};
      vecs[7] = '{OP_PIR, 2'd1, 8'h5A, 8'hFF, 8'h5A, 8'h3C, 8'h81};
      vecs[8] = '{OP_PIR, 2'd3, 8'h81, 8'hFF, 8'h5A, 8'h3C, 8'h81};

      // Reset state
      #12;
      check("rst_td", td, 8'h00);
      check("rst_rc", rc, 8'h00);
      check("rst_oe", r_nib_oe, 1'b0);
      check("rst_busy", pi_busy, 1'b0);
      check("rst_irq", irq, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         case (vecs[i].op)
            OP_TIW: ti_write(vecs[i].sel[0], vecs[i].data);
            OP_PIW: pi_write(vecs[i].sel, vecs[i].data);
            default: pi_read(vecs[i].sel, vecs[i].data);
         endcase
         check($sformatf("vec%0d_td", i), td, vecs[i].exp_td);
         check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_rc", i), rc, vecs[i].exp_rc);
      end
      model[0] = 8'hFF; model[1] = 8'h5A; model[2] = 8'h3C; model[3] = 8'h81;

      // RC interrupt: set by Pi write to RC, cleared by TI read of RC
      ti_read_rc();
      check("irq_cleared", irq, 1'b0);
      pi_write(2'd3, 8'h01);
      model[3] = 8'h01;
      check("irq_set", irq, IRQ_EXP);
      check("irq_rc", rc, 8'h01);
      ti_read_rc();
      check("irq_read_clr", irq, 1'b0);

      // Collision: Pi write TC 0x77 meets TI write TC 0x11 in COMMIT
      pi_edge(1'b1, 4'b0110);
      pi_edge(1'b0, 4'h7);
      @(posedge clk); #1;
      r_le = 1'b0;
      r_nib_in = 4'h7;
      @(posedge clk); #1;
      r_clk = 1'b1;
      ti_sel = 1'b1;
      ti_wdata = 8'h11;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         ti_wr = 1'b1;
         @(posedge clk); #1;
         if (pi_wr_pending) seen = 1'b1;
      end
      ti_wr = 1'b0;
      check("coll_pending_seen", seen, 1'b1);
      check("coll_tc_ti_first", tc, 8'h11);
      @(posedge clk); #1;
      check("coll_tc_pi_next", tc, 8'h77);
      check("coll_pending_1cyc", pi_wr_pending, 1'b0);
      r_clk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      model[1] = 8'h77;
      check_model("coll");

      // Timeout after high nibble of a Pi write to RD
      pi_edge(1'b1, 4'b1010);
      pi_edge(1'b0, 4'h9);
      repeat (TO - 8) @(posedge clk);
      #1 check("to_busy_before", pi_busy, 1'b1);
      repeat (6) @(posedge clk);
      #1 check("to_busy_after", pi_busy, 1'b0);
      check("to_rd_unchanged", rd, model[2]);

      // Timeout during a read drops the pin driver
      pi_edge(1'b1, 4'b0000);
      check("to_rd_oe_before", r_nib_oe, 1'b1);
      repeat (TO + 2) @(posedge clk);
      #1 check("to_rd_oe_after", r_nib_oe, 1'b0);
      check("to_rd_busy_after", pi_busy, 1'b0);

      // Abort: new command mid-write restarts as a read of RC, no write lands
      pi_edge(1'b1, 4'b1010);
      pi_edge(1'b0, 4'hE);
      pi_read(2'd3, model[3]);
      check_model("abort");

      // sync_clr beats a coincident TI write and clears irq
      pi_write(2'd3, 8'h42);
      model[3] = 8'h42;
      check("sclr_irq_pre", irq, IRQ_EXP);
      @(posedge clk); #1;
      sync_clr = 1'b1;
      ti_wr = 1'b1;
      ti_sel = 1'b0;
      ti_wdata = 8'h99;
      @(posedge clk); #1;
      sync_clr = 1'b0;
      ti_wr = 1'b0;
      model[0] = 8'h00; model[1] = 8'h00; model[2] = 8'h00; model[3] = 8'h00;
      check_model("sclr");
      check("sclr_irq", irq, 1'b0);

      // Random transactions against the mailbox model
      for (int i = 0; i < 40; i++) begin
         rop  = $urandom_range(0, 2);
         rs   = 2'($urandom_range(0, 3));
         rdat = 8'($urandom);
         case (rop)
            0: begin ti_write(rs[0], rdat); model[{1'b0, rs[0]}] = rdat; end
            1: begin pi_write(rs, rdat); model[rs] = rdat; end
            default: pi_read(rs, model[rs]);
         endcase
         check_model($sformatf("rand%0d", i));
      end

      // Asynchronous reset in the middle of a read
      ti_write(1'b0, 8'hC3);
      pi_edge(1'b1, 4'b0000);
      check("arst_oe_pre", r_nib_oe, 1'b1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("arst_td", td, 8'h00);
      check("arst_oe", r_nib_oe, 1'b0);
      check("arst_busy", pi_busy, 1'b0);
      check("arst_out", r_nib_out, 4'h0);
      #20;
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
